// File: rtl/router_out_buffer.sv
// router_out_buffer
//   Show-ahead output FIFO behind one router output port. Words that the
//   consumer leaves unread at the head for TIMEOUT cycles cause the whole
//   buffer to be flushed, so a stuck consumer cannot wedge the router.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset, synchronous release
//   wr_valid     write strobe from the router (valid_out[n])
//   wr_data      write word from the router (data_out[n])
//   rd_ready     consumer accepts the head word
//   rd_valid     head word available
//   rd_data      head word (show-ahead), don't-care when rd_valid=0
//   full/empty   decoded from the registered occupancy
//   count        occupancy, 0..DEPTH
//   drop_pulse   one cycle, the cycle after a write was lost
//   flush_pulse  high for the single FLUSH cycle
//   drop_count   saturating count of lost writes
module router_out_buffer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_pulse,
  output logic                     flush_pulse,
  output logic [7:0]               drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FLUSH} state_t;

  state_t                         state;
  logic [DEPTH-1:0][WIDTH-1:0]    mem;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [STALL_W-1:0]             stall;
  logic [CNT_W-1:0]               count_nxt;
  logic                           push, pop, timeout;

  // Status is decoded from registers only; rd_ready/wr_valid never reach
  // full, empty or rd_valid.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_W'(DEPTH));
    rd_valid = !empty && (state != ST_FLUSH);
    rd_data  = mem[rd_ptr];
    pop      = rd_valid && rd_ready;
    // A pop frees a slot in the same edge, so a full FIFO still takes a write.
    push     = wr_valid && (state != ST_FLUSH) && (!full || pop);
    // Head has already sat unread for TIMEOUT-1 cycles and is not taken now.
    timeout  = (state == ST_ACTIVE) && !rd_ready && (stall == STALL_W'(TIMEOUT - 1));
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stall       <= '0;
      drop_count  <= '0;
      drop_pulse  <= 1'b0;
      flush_pulse <= 1'b0;
    end else begin
      drop_pulse  <= wr_valid && !push;
      flush_pulse <= 1'b0;
      if (wr_valid && !push && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      if (state == ST_FLUSH) begin
        // Everything buffered is discarded; writes this cycle were dropped above.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        stall  <= '0;
        state  <= ST_EMPTY;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
        if (timeout) begin
          state       <= ST_FLUSH;
          flush_pulse <= 1'b1;
          stall       <= '0;
        end else begin
          // ACTIVE exactly when something is buffered.
          state <= (count_nxt == '0) ? ST_EMPTY : ST_ACTIVE;
          if (pop || state == ST_EMPTY)
            stall <= '0;
          else if (rd_valid && !rd_ready)
            stall <= stall + 1'b1;
        end
      end
    end
  end

endmodule
